// File: rtl/gf4_mul_dom.sv
// Two-share domain-oriented-masking GF(2^4) multiplier (poly x^4+x+1) with a 2-stage pipeline.
// Optional macro DOM_INPUT_REG_EN adds an input register stage, making the latency 3 cycles.
module gf4_mul_dom (
  input  logic       clk,
  input  logic       rst,
  input  logic       EnxSI,
  input  logic       ValidInxSI,
  input  logic [3:0] AxDI [2],
  input  logic [3:0] BxDI [2],
  input  logic [3:0] ZxDI,
  output logic [3:0] QxDO [2],
  output logic       ValidOutxSO,
  output logic       RandUsedxSO
);

  // Shift-and-add multiply; the reduction folds x^4 back in as x+1 (4'h3).
  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] acc;
    logic [3:0] sh;
    acc = 4'h0;
    sh  = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) acc = acc ^ sh;
      sh = {sh[2:0], 1'b0} ^ (sh[3] ? 4'h3 : 4'h0);
    end
    return acc;
  endfunction

  logic [3:0] w_a0, w_a1, w_b0, w_b1, w_z;
  logic       w_vin;

`ifdef DOM_INPUT_REG_EN
  logic [3:0] r_a0, r_a1, r_b0, r_b1, r_z;
  logic       r_vin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a0  <= 4'h0;
      r_a1  <= 4'h0;
      r_b0  <= 4'h0;
      r_b1  <= 4'h0;
      r_z   <= 4'h0;
      r_vin <= 1'b0;
    end else if (EnxSI) begin
      r_a0  <= AxDI[0];
      r_a1  <= AxDI[1];
      r_b0  <= BxDI[0];
      r_b1  <= BxDI[1];
      r_z   <= ZxDI;
      r_vin <= ValidInxSI;
    end
  end

  assign w_a0  = r_a0;
  assign w_a1  = r_a1;
  assign w_b0  = r_b0;
  assign w_b1  = r_b1;
  assign w_z   = r_z;
  assign w_vin = r_vin;
`else
  assign w_a0  = AxDI[0];
  assign w_a1  = AxDI[1];
  assign w_b0  = BxDI[0];
  assign w_b1  = BxDI[1];
  assign w_z   = ZxDI;
  assign w_vin = ValidInxSI;
`endif

  // Stage 1: each term stays in its own register so no share domains meet before the flops.
  logic [3:0] w_p00, w_p11, w_c01, w_c10;

  always_comb begin
    w_p00 = gf_mul(w_a0, w_b0);
    w_p11 = gf_mul(w_a1, w_b1);
    w_c01 = gf_mul(w_a0, w_b1) ^ w_z;
    w_c10 = gf_mul(w_a1, w_b0) ^ w_z;
  end

  logic [3:0] r_p00, r_p11, r_c01, r_c10;
  logic       r_v1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p00 <= 4'h0;
      r_p11 <= 4'h0;
      r_c01 <= 4'h0;
      r_c10 <= 4'h0;
      r_v1  <= 1'b0;
    end else if (EnxSI) begin
      r_p00 <= w_p00;
      r_p11 <= w_p11;
      r_c01 <= w_c01;
      r_c10 <= w_c10;
      r_v1  <= w_vin;
    end
  end

  // Stage 2: cross-domain integration happens only on registered terms.
  logic [3:0] r_q0, r_q1;
  logic       r_v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q0 <= 4'h0;
      r_q1 <= 4'h0;
      r_v2 <= 1'b0;
    end else if (EnxSI) begin
      r_q0 <= r_p00 ^ r_c01;
      r_q1 <= r_p11 ^ r_c10;
      r_v2 <= r_v1;
    end
  end

  // Pulse flag: updated every clock so it is high for exactly one cycle after Z is consumed.
  logic r_rand_used;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rand_used <= 1'b0;
    end else begin
      r_rand_used <= EnxSI & w_vin;
    end
  end

  assign QxDO[0]     = r_q0;
  assign QxDO[1]     = r_q1;
  assign ValidOutxSO = r_v2;
  assign RandUsedxSO = r_rand_used;

endmodule

// File: tb/tb_gf4_mul_dom.sv
// Self-checking bench for gf4_mul_dom: directed vector table plus randomized streams
// compared against a queue-based reference model.
module tb_gf4_mul_dom;

`ifdef DOM_INPUT_REG_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       EnxSI;
  logic       ValidInxSI;
  logic [3:0] AxDI [2];
  logic [3:0] BxDI [2];
  logic [3:0] ZxDI;
  logic [3:0] QxDO [2];
  logic       ValidOutxSO;
  logic       RandUsedxSO;

  gf4_mul_dom dut (
    .clk         (clk),
    .rst         (rst),
    .EnxSI       (EnxSI),
    .ValidInxSI  (ValidInxSI),
    .AxDI        (AxDI),
    .BxDI        (BxDI),
    .ZxDI        (ZxDI),
    .QxDO        (QxDO),
    .ValidOutxSO (ValidOutxSO),
    .RandUsedxSO (RandUsedxSO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] a0, a1, b0, b1, z;
  } beat_t;

  typedef struct {
    logic [3:0] a0, a1, b0, b1, z;
    logic [3:0] q0, q1;
  } vec_t;

  int    n_checks = 0;
  int    n_fail   = 0;
  int    cnt_v    = 0;
  int    cnt_r    = 0;
  beat_t hist[$];
  vec_t  tbl[6];

  // Carry-less product then polynomial reduction by x^4+x+1 (0x13).
  function automatic logic [3:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    int p = 0;
    for (int i = 0; i < 4; i++) if (b[i]) p = p ^ (int'(a) << i);
    for (int k = 6; k >= 4; k--) if (p[k]) p = p ^ (32'h13 << (k - 4));
    return p[3:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, let one edge pass, then compare against the model.
  task automatic step(input logic en, input logic vin, input logic [3:0] a0, input logic [3:0] a1,
                      input logic [3:0] b0, input logic [3:0] b1, input logic [3:0] z);
    beat_t b;
    logic  exp_v;
    logic  exp_r;
    logic [3:0] e0, e1;
    EnxSI = en; ValidInxSI = vin;
    AxDI[0] = a0; AxDI[1] = a1; BxDI[0] = b0; BxDI[1] = b1; ZxDI = z;
    @(posedge clk);
    #1;
    if (en) begin
      b.v = vin; b.a0 = a0; b.a1 = a1; b.b0 = b0; b.b1 = b1; b.z = z;
      hist.push_back(b);
    end
    exp_v = (hist.size() >= Lat) && hist[hist.size() - Lat].v;
    exp_r = en && (hist.size() >= Lat - 1) && hist[hist.size() - (Lat - 1)].v;
    check("valid_out", 32'(ValidOutxSO), 32'(exp_v));
    check("rand_used", 32'(RandUsedxSO), 32'(exp_r));
    if (exp_v) begin
      b  = hist[hist.size() - Lat];
      e0 = ref_mul(b.a0, b.b0) ^ ref_mul(b.a0, b.b1) ^ b.z;
      e1 = ref_mul(b.a1, b.b1) ^ ref_mul(b.a1, b.b0) ^ b.z;
      check("q0", 32'(QxDO[0]), 32'(e0));
      check("q1", 32'(QxDO[1]), 32'(e1));
      check("q_unmasked", 32'(QxDO[0] ^ QxDO[1]),
            32'(ref_mul(b.a0 ^ b.a1, b.b0 ^ b.b1)));
    end
    if (ValidOutxSO) cnt_v++;
    if (RandUsedxSO) cnt_r++;
    while (hist.size() > Lat) void'(hist.pop_front());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic rand_beat(input logic [3:0] a, input logic [3:0] b, input logic en,
                           input logic vin);
    logic [3:0] ra, rb;
    ra = 4'($urandom);
    rb = 4'($urandom);
    step(en, vin, ra, a ^ ra, rb, b ^ rb, 4'($urandom));
  endtask

  initial begin
    tbl[0] = '{a0: 4'h5, a1: 4'h7, b0: 4'hC, b1: 4'hF, z: 4'h9, q0: 4'h6, q1: 4'h0};
    tbl[1] = '{a0: 4'h8, a1: 4'h0, b0: 4'h2, b1: 4'h0, z: 4'h0, q0: 4'h3, q1: 4'h0};
    tbl[2] = '{a0: 4'hF, a1: 4'h0, b0: 4'hF, b1: 4'h0, z: 4'h0, q0: 4'hA, q1: 4'h0};
    tbl[3] = '{a0: 4'hF, a1: 4'h0, b0: 4'hF, b1: 4'h0, z: 4'h5, q0: 4'hF, q1: 4'h5};
    tbl[4] = '{a0: 4'h0, a1: 4'h0, b0: 4'h0, b1: 4'h0, z: 4'hA, q0: 4'hA, q1: 4'hA};
    tbl[5] = '{a0: 4'h1, a1: 4'h0, b0: 4'h0, b1: 4'h1, z: 4'h0, q0: 4'h1, q1: 4'h0};

    rst = 1'b1; EnxSI = 1'b0; ValidInxSI = 1'b0;
    AxDI[0] = 4'h0; AxDI[1] = 4'h0; BxDI[0] = 4'h0; BxDI[1] = 4'h0; ZxDI = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_q0", 32'(QxDO[0]), 32'h0);
    check("reset_q1", 32'(QxDO[1]), 32'h0);
    check("reset_valid", 32'(ValidOutxSO), 32'h0);
    check("reset_rand_used", 32'(RandUsedxSO), 32'h0);
    rst = 1'b0;
    hist.delete();

    // Directed vectors, each isolated by idle beats.
    foreach (tbl[i]) begin
      step(1'b1, 1'b1, tbl[i].a0, tbl[i].a1, tbl[i].b0, tbl[i].b1, tbl[i].z);
      idle(Lat - 1);
      check($sformatf("tbl%0d_valid", i), 32'(ValidOutxSO), 32'h1);
      check($sformatf("tbl%0d_q0", i), 32'(QxDO[0]), 32'(tbl[i].q0));
      check($sformatf("tbl%0d_q1", i), 32'(QxDO[1]), 32'(tbl[i].q1));
    end
    idle(Lat);

    // Exhaustive A x B sweep, back-to-back, random shares and Z.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        rand_beat(4'(a), 4'(b), 1'b1, 1'b1);
    idle(Lat);

    // Valid beat then three stalled cycles: outputs frozen, result after Lat enabled cycles.
    step(1'b1, 1'b1, 4'h5, 4'h7, 4'hC, 4'hF, 4'h9);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      check("stall_no_valid", 32'(ValidOutxSO), 32'h0);
    end
    idle(Lat - 1);
    check("stall_result_q0", 32'(QxDO[0]), 32'h6);
    check("stall_result_q1", 32'(QxDO[1]), 32'h0);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      check("stall_hold_valid", 32'(ValidOutxSO), 32'h1);
      check("stall_hold_q0", 32'(QxDO[0]), 32'h6);
    end
    idle(Lat);

    // Reset pulse with two beats in flight.
    rand_beat(4'h9, 4'h4, 1'b1, 1'b1);
    rand_beat(4'h3, 4'hE, 1'b1, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midrst_q0", 32'(QxDO[0]), 32'h0);
    check("midrst_q1", 32'(QxDO[1]), 32'h0);
    check("midrst_valid", 32'(ValidOutxSO), 32'h0);
    check("midrst_rand_used", 32'(RandUsedxSO), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    hist.delete();
    cnt_v = 0;
    idle(Lat + 1);
    check("postrst_no_stale", 32'(cnt_v), 32'h0);
    rand_beat(4'h6, 4'hB, 1'b1, 1'b1);
    idle(Lat);

    // 16 consecutive valid beats.
    cnt_v = 0;
    cnt_r = 0;
    for (int i = 0; i < 16; i++) rand_beat(4'($urandom), 4'($urandom), 1'b1, 1'b1);
    idle(Lat);
    check("burst_valid_cycles", 32'(cnt_v), 32'd16);
    check("burst_rand_used_cycles", 32'(cnt_r), 32'd16);

    // Random mix of enable and valid.
    for (int i = 0; i < 300; i++)
      rand_beat(4'($urandom), 4'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    idle(Lat);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gf4_mul_dom.md
GF4_MUL_DOM -- requirements
Module: gf4_mul_dom

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port EnxSI  input  1  pipeline enable; all stages advance only when high.
REQ-004 SHALL have port ValidInxSI  input  1  operands and randomness valid this cycle.
REQ-005 SHALL have ports AxDI[0], AxDI[1]  input  4 each  Boolean shares of operand A, which is a lin_map output nibble.
REQ-006 SHALL have ports BxDI[0], BxDI[1]  input  4 each  Boolean shares of operand B.
REQ-007 SHALL have port ZxDI  input  4  fresh randomness for cross-domain resharing.
REQ-008 SHALL have ports QxDO[0], QxDO[1]  output  4 each  shares of the product Q = A*B.
REQ-009 SHALL have port ValidOutxSO  output  1  QxDO holds a valid result.
REQ-010 SHALL have port RandUsedxSO  output  1  pulses one cycle when ZxDI has been consumed.

Function
REQ-011 SHALL multiply in GF(2^4), polynomial basis, reduction x^4+x+1, bit 0 = x^0 coefficient.
REQ-012 SHALL compute the inner terms P00 = A0*B0 and P11 = A1*B1.
REQ-013 SHALL compute the cross terms C01 = A0*B1 ^ Z and C10 = A1*B0 ^ Z.
REQ-014 SHALL register all four terms in stage 1 (DOM-indep) before any cross-domain XOR.
REQ-015 SHALL compute stage 2 as Q0 = P00 ^ C01 and Q1 = P11 ^ C10, with both outputs registered.
REQ-016 SHALL give a base latency of 2 EnxSI-high cycles from input capture to QxDO/ValidOutxSO.
REQ-017 SHALL carry a valid bit alongside each stage; ValidOutxSO is the stage-2 valid bit.
REQ-018 SHALL hold every register, including the valid bits, when EnxSI=0; outputs stay stable.
REQ-019 SHALL capture ZxDI only when EnxSI=1 and ValidInxSI=1; RandUsedxSO is high in the next cycle only.
REQ-020 SHALL advance invalid beats through the pipeline with data registers loaded (no gating) but valid bit 0; QxDO is don't-care when ValidOutxSO=0.
REQ-021 SHALL accept back-to-back valid beats every EnxSI-high cycle (throughput of 1/cycle).
REQ-022 SHALL never combine the two share domains combinationally without the stage-1 register in between.

Reset
REQ-023 SHALL clear all data registers to 0x0, all valid bits to 0, and RandUsedxSO to 0 while rst=1, independent of clk.
REQ-024 SHALL discard in-flight beats when rst asserts mid-operation; the first valid output after release comes from a beat captured after release.

Configuration
REQ-025 SHALL, when macro DOM_INPUT_REG_EN is defined, add an input register stage (AxDI, BxDI, ZxDI, ValidInxSI) obeying EnxSI and rst; latency becomes 3 and RandUsedxSO moves to the cycle after stage-1 capture.
REQ-026 SHALL, without DOM_INPUT_REG_EN, feed stage 1 directly from the inputs with latency 2.

Verification
REQ-027 SHALL cover: A0=0x5, A1=0x7, B0=0xC, B1=0xF, Z=0x9, EnxSI=1 -> after 2 cycles Q0=0x6, Q1=0x0, ValidOutxSO=1.
REQ-028 SHALL cover an exhaustive sweep of A, B over 0..15 with random shares and Z -> Q0^Q1 equals the reference GF(2^4) product (e.g. 8*2=0x3, 0xF*0xF=0xA).
REQ-029 SHALL cover a valid beat followed by EnxSI=0 for 3 cycles -> outputs and ValidOutxSO frozen, result appearing 2 enabled cycles after capture.
REQ-030 SHALL cover rst pulsed while two beats are in flight -> QxDO=0x0, ValidOutxSO=0 immediately, with no stale valid after release.
REQ-031 SHALL cover 16 consecutive valid beats -> 16 consecutive ValidOutxSO cycles, correct order, and RandUsedxSO high 16 cycles.
REQ-032 SHALL cover a build with DOM_INPUT_REG_EN defined and the REQ-027 stimulus -> the same Q0=0x6, Q1=0x0 after 3 cycles.
